// File: rtl/decoder_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decoder_core : hard-decision Viterbi decoder, rate 1/2, K=3 (111, 101)   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module decoder_core (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] rstring,
   input  logic [2:0]  size,
   output logic [6:0]  dstring,
   output logic        done
);

   localparam int METRIC_W = 5;
   localparam logic [METRIC_W-1:0] INIT_METRIC = 5'd15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACS   = 2'd1,
      TRACE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state, state_next;

   logic [13:0]         rstring_q;
   logic [2:0]          size_q;
   logic [2:0]          step;
   logic [METRIC_W-1:0] metric     [4];
   logic [METRIC_W-1:0] metric_new [4];
   logic [METRIC_W-1:0] cand0      [4];
   logic [METRIC_W-1:0] cand1      [4];
   logic [3:0]          dec_new;
   logic [3:0]          surv       [7];
   logic [1:0]          sym;
   logic [1:0]          best;
   logic [1:0]          trace_st;
   logic [6:0]          bits;
   logic                last_acs;
   logic                last_trace;

   // Hamming distance between the branch output of (prev state, input u) and the received symbol
   function automatic logic [1:0] branch_dist(input logic [1:0] prev, input logic u,
                                              input logic [1:0] rx);
      logic g0, g1;
      g0 = u ^ prev[1] ^ prev[0];
      g1 = u ^ prev[0];
      return {1'b0, g0 ^ rx[1]} + {1'b0, g1 ^ rx[0]};
   endfunction

   // State {a,b} is reached from predecessors {b,0} and {b,1} with input bit a
   always_comb begin
      sym     = rstring_q[{step, 1'b0} +: 2];
      dec_new = '0;
      for (int s = 0; s < 4; s++) begin
         cand0[s]      = '0;
         cand1[s]      = '0;
         metric_new[s] = '0;
      end
      for (int s = 0; s < 4; s++) begin
         cand0[s] = metric[{s[0], 1'b0}]
                    + {3'b000, branch_dist({s[0], 1'b0}, s[1], sym)};
         cand1[s] = metric[{s[0], 1'b1}]
                    + {3'b000, branch_dist({s[0], 1'b1}, s[1], sym)};
         dec_new[s]    = (cand1[s] < cand0[s]);
         metric_new[s] = dec_new[s] ? cand1[s] : cand0[s];
      end
      best = 2'd0;
      for (int s = 1; s < 4; s++) begin
         if (metric_new[s] < metric_new[best]) best = 2'(s);
      end
   end

   assign last_acs   = (step == size_q - 3'd1);
   assign last_trace = (step == 3'd0);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = (size == 3'd0) ? DONE : ACS;
         ACS:     if (last_acs) state_next = TRACE;
         TRACE:   if (last_trace) state_next = DONE;
         DONE:    state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rstring_q <= '0;
         size_q    <= '0;
         step      <= '0;
         trace_st  <= '0;
         bits      <= '0;
         dstring   <= '0;
         done      <= 1'b0;
         for (int i = 0; i < 4; i++) metric[i] <= '0;
         for (int i = 0; i < 7; i++) surv[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               rstring_q <= rstring;
               size_q    <= size;
               step      <= '0;
               bits      <= '0;
               metric[0] <= '0;
               for (int i = 1; i < 4; i++) metric[i] <= INIT_METRIC;
               if (size == 3'd0) begin
                  dstring <= '0;
                  done    <= 1'b1;
               end
            end
            ACS: begin
               for (int i = 0; i < 4; i++) metric[i] <= metric_new[i];
               surv[step] <= dec_new;
               // step is reused as the trace bit index, which starts at size-1
               if (last_acs) trace_st <= best;
               else          step     <= step + 3'd1;
            end
            TRACE: begin
               bits[step] <= trace_st[1];
               trace_st   <= {trace_st[0], surv[step][trace_st]};
               if (last_trace) begin
                  dstring <= bits | {6'b000000, trace_st[1]};
                  done    <= 1'b1;
               end else begin
                  step <= step - 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_decoder_core.sv
`default_nettype none
// tb_decoder_core : directed and random decodes against a register-exchange Viterbi model
module tb_decoder_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [13:0] rstring = '0;
   logic [2:0]  size = '0;
   logic [6:0]  dstring;
   logic        done;

   int tests = 0;
   int fails = 0;

   decoder_core dut (
      .clk     (clk),
      .rst     (rst),
      .rstring (rstring),
      .size    (size),
      .dstring (dstring),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Survivor paths are carried along as whole message words
   function automatic logic [6:0] ref_decode(input logic [13:0] rs, input int n);
      int pm [4];
      int npm [4];
      logic [6:0] path [4];
      logic [6:0] npath [4];
      int r0, r1, u, m1, g0, g1, d, bestd, bp, ps, win;
      pm = '{0, 1000, 1000, 1000};
      for (int i = 0; i < 4; i++) begin
         path[i]  = '0;
         npath[i] = '0;
         npm[i]   = 0;
      end
      for (int t = 0; t < n; t++) begin
         r0 = rs[2*t+1] ? 1 : 0;
         r1 = rs[2*t]   ? 1 : 0;
         for (int ns = 0; ns < 4; ns++) begin
            u = ns / 2;
            m1 = ns % 2;
            bestd = -1;
            bp = 0;
            for (int m2 = 0; m2 < 2; m2++) begin
               ps = m1 * 2 + m2;
               g0 = (u + m1 + m2) % 2;
               g1 = (u + m2) % 2;
               d  = pm[ps] + ((g0 != r0) ? 1 : 0) + ((g1 != r1) ? 1 : 0);
               if (bestd < 0 || d < bestd) begin
                  bestd = d;
                  bp = ps;
               end
            end
            npm[ns]      = bestd;
            npath[ns]    = path[bp];
            npath[ns][t] = (u == 1);
         end
         pm   = npm;
         path = npath;
      end
      win = 0;
      for (int ns = 1; ns < 4; ns++) if (pm[ns] < pm[win]) win = ns;
      return path[win];
   endfunction

   task automatic run_decode(input logic [13:0] rs, input logic [2:0] sz,
                             output int lat, output logic [6:0] ds, output logic quiet);
      @(negedge clk);
      rst = 1'b1;
      rstring = rs;
      size = sz;
      @(posedge clk);
      #1;
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_dstring", {25'd0, dstring}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      lat = -1;
      quiet = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            lat = e;
            break;
         end
         if (dstring !== 7'd0) quiet = 1'b0;
         if (e == 1) begin
            rstring = 14'($urandom);
            size = 3'($urandom);
         end
      end
      ds = dstring;
   endtask

   initial begin
      int         lat;
      logic [6:0] ds;
      logic       quiet;
      logic [13:0] rs;
      logic [2:0]  sz;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("init_done", {31'd0, done}, 32'd0);
      check("init_dstring", {25'd0, dstring}, 32'd0);

      run_decode(14'b00000000_001011, 3'd3, lat, ds, quiet);
      check("clean_latency", 32'(lat), 32'd7);
      check("clean_dstring", {25'd0, ds}, 32'h05);
      check("clean_no_partial", {31'd0, quiet}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("clean_hold_done", {31'd0, done}, 32'd1);
      check("clean_hold_dstring", {25'd0, dstring}, 32'h05);

      run_decode(14'd0, 3'd7, lat, ds, quiet);
      check("zero_latency", 32'(lat), 32'd15);
      check("zero_dstring", {25'd0, ds}, 32'd0);

      run_decode(14'b00000000000010, 3'd7, lat, ds, quiet);
      check("err1_latency", 32'(lat), 32'd15);
      check("err1_dstring", {25'd0, ds}, 32'd0);

      rs = 14'b00001101101010;
      run_decode(rs, 3'd3, lat, ds, quiet);
      check("arb_latency", 32'(lat), 32'd7);
      check("arb_upper_zero", {28'd0, ds[6:3]}, 32'd0);
      check("arb_dstring", {25'd0, ds}, {25'd0, ref_decode(rs, 3)});

      run_decode(14'd0, 3'd0, lat, ds, quiet);
      check("size0_latency", 32'(lat), 32'd1);
      check("size0_dstring", {25'd0, ds}, 32'd0);

      run_decode(14'b11, 3'd1, lat, ds, quiet);
      check("size1_latency", 32'(lat), 32'd3);
      check("size1_dstring", {25'd0, ds}, 32'h01);

      // Abort a size-7 decode partway through TRACE (edges 9..15)
      @(negedge clk);
      rst = 1'b1;
      rstring = 14'h3fff;
      size = 3'd7;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      check("abort_pre_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_dstring", {25'd0, dstring}, 32'd0);
      run_decode(14'b00000000_001011, 3'd3, lat, ds, quiet);
      check("after_abort_latency", 32'(lat), 32'd7);
      check("after_abort_dstring", {25'd0, ds}, 32'h05);

      for (int k = 0; k < 12; k++) begin
         rs = 14'($urandom);
         sz = 3'($urandom_range(1, 7));
         run_decode(rs, sz, lat, ds, quiet);
         check("rand_latency", 32'(lat), 32'(1 + 2 * int'(sz)));
         check("rand_dstring", {25'd0, ds}, {25'd0, ref_decode(rs, int'(sz))});
         check("rand_no_partial", {31'd0, quiet}, 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
